wb_master_behavioral: RTL

- Command-driven Wishbone initiator for the BA22 bench; opposite end of the Wishbone slave RAM/monitor models.
- Accepts single read/write commands from a testbench task interface and drives one classic Wishbone cycle per command.
- Returns read data or an error flag as a one-cycle response pulse.
- Keeps read and write transaction counters for end-of-test checks.

---
 rtl/wb_master_behavioral.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/wb_master_behavioral.sv
// Command-driven classic Wishbone initiator: one bus cycle per command, one-cycle response pulse.
// Optional bus-wait timeout abort is enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_behavioral #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [AW-1:0]   cmd_adr_i,
    input  logic [DW-1:0]   cmd_dat_i,
    input  logic [DW/8-1:0] cmd_sel_i,
    output logic            rsp_valid_o,
    output logic [DW-1:0]   rsp_dat_o,
    output logic            rsp_err_o,
    output logic [AW-1:0]   adr_o,
    output logic [DW-1:0]   dat_o,
    input  logic [DW-1:0]   dat_i,
    output logic [DW/8-1:0] sel_o,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    input  logic            ack_i,
    output logic [9:0]      rd_cnt_o,
    output logic [9:0]      wr_cnt_o
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t state, state_nxt;
    logic   timeout_hit;

    if (!(DW == 32 || DW == 64 || DW == 128)) begin : g_bad_dw
        $error("wb_master_behavioral: DW must be 32, 64 or 128");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_master_behavioral: TIMEOUT must be in 1..65535");
    end

`ifdef WB_MASTER_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // ack_i on the same edge wins over the timeout.
    assign timeout_hit = (state == BUS) && !ack_i && (wait_cnt == 16'(TIMEOUT));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt  <= '0;
            rsp_err_o <= 1'b0;
        end else begin
            case (state)
                IDLE: wait_cnt <= '0;
                BUS: begin
                    if (timeout_hit)
                        rsp_err_o <= 1'b1;
                    else if (!ack_i)
                        wait_cnt <= wait_cnt + 16'd1;
                end
                default: rsp_err_o <= 1'b0;
            endcase
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err_o   = 1'b0;
`endif

    // NOTE: reset is synchronous here, so it lives inside the clocked branch, not the sensitivity list.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid_i) state_nxt = BUS;
            BUS:     if (ack_i || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o = (state == IDLE);
    end

    // NOTE: registered outputs use non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            adr_o       <= '0;
            dat_o       <= '0;
            sel_o       <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rd_cnt_o    <= '0;
            wr_cnt_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid_o <= 1'b0;
                    if (cmd_valid_i) begin
                        we_o  <= cmd_we_i;
                        adr_o <= cmd_adr_i;
                        dat_o <= cmd_dat_i;
                        sel_o <= cmd_sel_i;
                        cyc_o <= 1'b1;
                        stb_o <= 1'b1;
                    end
                end
                BUS: begin
                    if (ack_i) begin
                        cyc_o       <= 1'b0;
                        stb_o       <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_dat_o   <= we_o ? '0 : dat_i;
                        if (we_o)
                            wr_cnt_o <= wr_cnt_o + 10'd1;
                        else
                            rd_cnt_o <= rd_cnt_o + 10'd1;
                    end else if (timeout_hit) begin
                        cyc_o       <= 1'b0;
                        stb_o       <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_dat_o   <= '0;
                    end
                end
                default: rsp_valid_o <= 1'b0;
            endcase
        end
    end

endmodule
